// File: rtl/router_sw_alloc.sv
// Wormhole switch allocator for a 5-port mesh router: per-output round-robin
// grant with lock until tail. Optional stall watchdog under SW_ALLOC_WDOG_EN.
module router_sw_alloc #(
  parameter int NUM_PORTS   = 5,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   in_valid,
  input  logic [NUM_PORTS-1:0]   in_head,
  input  logic [NUM_PORTS-1:0]   in_tail,
  input  logic [3*NUM_PORTS-1:0] in_route,
  input  logic [NUM_PORTS-1:0]   out_ready,
  output logic [NUM_PORTS-1:0]   in_ready,
  output logic [NUM_PORTS-1:0]   out_valid,
  output logic [3*NUM_PORTS-1:0] xbar_sel,
  output logic                   wdog_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [NUM_PORTS-1:0] own_oh [NUM_PORTS];
  logic [NUM_PORTS-1:0] pop_oh [NUM_PORTS];
  logic [NUM_PORTS-1:0] is_owner;
`ifdef SW_ALLOC_WDOG_EN
  logic [NUM_PORTS-1:0] stall_hit;
`endif

  // An input owns at most one output, so OR-reducing the one-hot views is exact.
  always_comb begin
    is_owner = '0;
    in_ready = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      is_owner = is_owner | own_oh[o];
      in_ready = in_ready | pop_oh[o];
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
      logic [0:0]           state_reg;
      logic [2:0]           owner_reg;
      logic [2:0]           rr_reg;
      logic                 locked;
      logic                 xfer;
      logic                 fin;
      logic                 hit;
      logic [2:0]           widx;
      logic [NUM_PORTS-1:0] req;

      assign locked          = (state_reg == ST_LOCKED);
      assign xfer            = locked & in_valid[owner_reg] & out_ready[gi];
      assign fin             = xfer & in_tail[owner_reg];
      assign out_valid[gi]   = locked & in_valid[owner_reg];
      assign xbar_sel[3*gi +: 3] = locked ? owner_reg : 3'b111;
      assign own_oh[gi]      = locked ? (NUM_PORTS'(1) << owner_reg) : '0;
      assign pop_oh[gi]      = xfer ? own_oh[gi] : '0;

      for (gj = 0; gj < NUM_PORTS; gj++) begin : g_req
        assign req[gj] = in_valid[gj] & in_head[gj] & ~is_owner[gj] &
                         (in_route[3*gj +: 3] == 3'(gi));
      end

      // Search from rr_reg upward, wrapping at NUM_PORTS.
      always_comb begin
        int idx;
        idx  = 0;
        hit  = 1'b0;
        widx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = int'(rr_reg) + k;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          if (!hit && req[idx]) begin
            hit  = 1'b1;
            widx = 3'(idx);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= ST_IDLE;
          owner_reg <= '0;
          rr_reg    <= '0;
        end else if (locked) begin
          if (fin) begin
            state_reg <= ST_IDLE;
            rr_reg    <= (owner_reg == 3'(NUM_PORTS-1)) ? 3'd0 : owner_reg + 3'd1;
          end
        end else if (hit) begin
          state_reg <= ST_LOCKED;
          owner_reg <= widx;
        end
      end

`ifdef SW_ALLOC_WDOG_EN
      logic [15:0] wdog_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst || !locked || xfer) begin
          wdog_cnt_reg <= '0;
        end else if (wdog_cnt_reg != 16'hffff) begin
          wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
        end
      end

      // Fires on the stalled cycle that brings the count to WDOG_CYCLES.
      assign stall_hit[gi] = locked & ~xfer &
                             (({1'b0, wdog_cnt_reg} + 17'd1) >= 17'(WDOG_CYCLES));
`endif
    end
  endgenerate

`ifdef SW_ALLOC_WDOG_EN
  logic wdog_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_err_reg <= 1'b0;
    end else if (|stall_hit) begin
      wdog_err_reg <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  assign wdog_err = 1'b0;
`endif

endmodule
